mul_2_seq_accum: RTL and testbench

- Sequential unsigned W×W multiplier that sits directly downstream of the 2-bit × 2-bit combinational multiplier stage.
- Splits each operand into 2-bit digits and feeds one digit pair per cycle into one instance of the 2×2 multiplier.
- Shifts each 4-bit partial product by its digit weight and accumulates it into a 2W-bit result.
- Trades latency for area in the FPGA examples datapath; uses a start/busy/done handshake.

---
 rtl/mul_2_seq_accum.sv | 106 ++++++++++
 tb/tb_mul_2_seq_accum.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mul_2_seq_accum.sv
// Sequential unsigned W x W multiplier: walks 2-bit digit pairs through one 2x2
// multiplier and accumulates weighted partial products into a 2W-bit result.
module mul_2x2 (
  input  logic [1:0] i_x,
  input  logic [1:0] i_y,
  output logic [3:0] o_p
);
  assign o_p = {2'b00, i_x} * {2'b00, i_y};
endmodule

module mul_2_seq_accum #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int N  = W / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * W;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [CW-1:0] r_i;
  logic [CW-1:0] r_j;
  logic [PW-1:0] r_acc;
  logic [PW-1:0] r_product;

  logic [1:0]    w_a_dig;
  logic [1:0]    w_b_dig;
  logic [3:0]    w_pp;
  logic [CW:0]   w_dsum;
  logic [CW+1:0] w_sh;
  logic [PW-1:0] w_pp_ext;
  logic [PW-1:0] w_acc_next;

  assign w_a_dig = r_a[{r_i, 1'b0} +: 2];
  assign w_b_dig = r_b[{r_j, 1'b0} +: 2];

  mul_2x2 u_mul (
    .i_x (w_a_dig),
    .i_y (w_b_dig),
    .o_p (w_pp)
  );

  // Digit pair (i, j) carries weight 4^(i+j), i.e. a left shift of 2(i+j).
  assign w_dsum     = {1'b0, r_i} + {1'b0, r_j};
  assign w_sh       = {w_dsum, 1'b0};
  assign w_pp_ext   = PW'(w_pp);
  assign w_acc_next = r_acc + (w_pp_ext << w_sh);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_product <= '0;
      r_i       <= '0;
      r_j       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          if (r_i == LAST) begin
            r_i <= '0;
            if (r_j == LAST) begin
              r_j       <= '0;
              r_product <= w_acc_next;
              r_state   <= S_DONE;
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_i <= r_i + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;
endmodule

// File: tb/tb_mul_2_seq_accum.sv
// Bench for mul_2_seq_accum: directed cases plus a random sweep, checked against
// plain a*b arithmetic and the start/busy/done timing rules.
module tb_mul_2_seq_accum;
  localparam int W  = 8;
  localparam int N  = W / 2;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  int n_chk = 0;
  int n_bad = 0;
  logic [PW-1:0] prev = '0;

  mul_2_seq_accum #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Issue one multiply at a negedge; optionally poke start while busy.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                       input bit inj, input int gap);
    logic [PW-1:0] want;
    int dc;
    int ndone;
    want = PW'(ta) * PW'(tbv);
    repeat (gap) @(negedge clk);
    a = ta;
    b = tbv;
    start = 1'b1;
    @(negedge clk);
    dc = 0;
    ndone = 0;
    for (int c = 1; c <= N*N + 2; c++) begin
      if (c == 1) begin
        chk("busy_run", busy, 1);
        chk("hold_prev", product, prev);
      end
      if (done === 1'b1) begin
        ndone++;
        if (dc == 0) dc = c;
        chk("product", product, want);
      end
      if (c == N*N + 2) chk("busy_drop", busy, 0);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      if (inj && (c == 5 || done === 1'b1)) begin
        start = 1'b1;
        a = '1;
        b = '1;
      end
      if (c < N*N + 2) @(negedge clk);
    end
    start = 1'b0;
    chk("latency", dc, N*N + 1);
    chk("done_count", ndone, 1);
    if (inj) begin
      @(negedge clk);
      chk("no_queue", busy, 0);
    end
    prev = want;
  endtask

  initial begin
    int nd;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    rst = 1'b0;

    do_op(8'hFF, 8'hFF, 1'b0, 0);
    do_op(8'h03, 8'h05, 1'b0, 0);
    do_op(8'h00, 8'hAB, 1'b0, 1);
    do_op(8'h80, 8'h02, 1'b0, 0);
    do_op(8'h02, 8'h80, 1'b0, 2);
    do_op(8'h12, 8'h34, 1'b1, 0);

    // Reset in the middle of a run discards it.
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_product", product, 0);
    nd = 0;
    for (int k = 0; k < 2*N*N; k++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("midrst_no_done", nd, 0);
    prev = '0;
    do_op(8'h10, 8'h10, 1'b0, 0);

    for (int k = 0; k < 1000; k++)
      do_op(W'($urandom), W'($urandom), 1'b0, int'($urandom_range(0, 3)));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
